// File: rtl/rf_pkg.sv
// Shared constants and FSM state type for the register-file arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rf_pkg;

  localparam int RF_AW    = 4;
  localparam int RF_DW    = 8;
  localparam int RF_DEPTH = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of eligible after 'last', with wrap.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; any=0 when nothing is eligible.
//   eligible : candidate vector
//   last     : index of the previous winner (search starts at last+1)
//   onehot   : one-hot winner, idx : winner index, any : a winner exists
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  int              cand;
  logic [IW-1:0]   cidx;

  // Walk offsets 1..N from the last winner; the first hit is kept and
  // later hits are ignored through the 'any' flag.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = 0;
    cidx   = '0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(last) + k) % N;
      cidx = cand[IW-1:0];
      if (!any && eligible[cidx]) begin
        any          = 1'b1;
        idx          = cidx;
        onehot[cidx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_arbiter.sv
// Round-robin arbiter sharing one register file among NUM_REQ requesters.
// Latency: gnt/RF controls 1 edge after req is sampled; rvalid/rdata 1 edge later.
// Backpressure: requester holds req until gnt; the just-granted requester is masked.
//   clk, reset (async, active-low)
//   req/req_we/req_addr/req_wdata : packed per-requester transactions
//   gnt, rvalid, rdata            : one-hot grant, one-hot read valid, read data
//   rf_rd_sel/rf_wr_sel/rf_wr_en/rf_data_in/rf_data_out : RF port
import rf_pkg::*;

module rf_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int AW      = RF_AW,
  parameter int DW      = RF_DW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    rvalid,
  output logic [DW-1:0]         rdata,
  output logic [AW-1:0]         rf_rd_sel,
  output logic [AW-1:0]         rf_wr_sel,
  output logic                  rf_wr_en,
  output logic [DW-1:0]         rf_data_in,
  input  logic [DW-1:0]         rf_data_out
);

  localparam int IW = $clog2(NUM_REQ);

  state_t             state;
  logic [IW-1:0]      last;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] win;
  logic [IW-1:0]      win_idx;
  logic               win_any;

  // A requester still holding req during its grant cycle must not win again.
  assign eligible = req & ~gnt;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .eligible (eligible),
    .last     (last),
    .onehot   (win),
    .idx      (win_idx),
    .any      (win_any)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last       <= IW'(NUM_REQ - 1);
      gnt        <= '0;
      rvalid     <= '0;
      rdata      <= '0;
      rf_rd_sel  <= '0;
      rf_wr_sel  <= '0;
      rf_wr_en   <= 1'b0;
      rf_data_in <= '0;
    end else begin
      // Close out the read issued in the cycle ending at this edge; the RF
      // output is combinational on rf_rd_sel so it is valid right now.
      if (state == ISSUE && !rf_wr_en) begin
        rvalid <= gnt;
        rdata  <= rf_data_out;
      end else begin
        rvalid <= '0;
      end

      if (win_any) begin
        state      <= ISSUE;
        gnt        <= win;
        last       <= win_idx;
        rf_rd_sel  <= req_addr[win_idx*AW +: AW];
        rf_wr_sel  <= req_addr[win_idx*AW +: AW];
        rf_data_in <= req_wdata[win_idx*DW +: DW];
        rf_wr_en   <= req_we[win_idx];
      end else begin
        state    <= IDLE;
        gnt      <= '0;
        rf_wr_en <= 1'b0;
      end
    end
  end

endmodule

// File: doc/rf_arbiter.md
Name: rf_arbiter

Overview:
- Round-robin arbiter that shares one 16x8 register file (RF) among NUM_REQ requesters.
- Each requester issues single read or write transactions.
- The arbiter drives the RF read and write ports and returns read data with a valid pulse.
- Sits between client blocks (ALU, load/store, debug) and the RF.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- AW, 4, RF address width.
- DW, 8, RF data width.

Ports:
- clk  in  1  clock, all state on posedge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester transaction request; held until gnt.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*AW  packed addresses, requester i at [i*AW +: AW].
- req_wdata  in  NUM_REQ*DW  packed write data, requester i at [i*DW +: DW].
- gnt  out  NUM_REQ  one-hot, one-cycle grant pulse.
- rvalid  out  NUM_REQ  one-hot, one-cycle read-data-valid pulse.
- rdata  out  DW  read data, valid when any rvalid bit is high.
- rf_rd_sel  out  AW  to RF rd_sel.
- rf_wr_sel  out  AW  to RF wr_sel.
- rf_wr_en  out  1  to RF wr_en.
- rf_data_in  out  DW  to RF data_in.
- rf_data_out  in  DW  from RF data_out; combinational read of rd_sel.

Behaviour:
- Reset (reset=0, asynchronous):
  - gnt=0, rvalid=0, rdata=0.
  - rf_wr_en=0, rf_rd_sel=0, rf_wr_sel=0, rf_data_in=0.
  - State IDLE; round-robin pointer last=NUM_REQ-1, so requester 0 wins first.
- Reset asserted mid-operation: a write in flight is dropped because rf_wr_en clears immediately, and no rvalid is produced.
- Outputs after reset release come from registers only.
- FSM states:
  - IDLE: rf_wr_en=0.
  - ISSUE: one transaction driven on the RF for exactly one cycle.
- Arbitration, each posedge:
  - Eligible set = req & ~gnt. The requester granted this cycle is masked, so a held req does not win twice.
  - If eligible is nonzero, the winner w is the first set bit searching from (last+1) mod NUM_REQ upward with wrap.
  - Register gnt=onehot(w), last=w, state ISSUE.
  - Register rf_rd_sel=addr[w], rf_wr_sel=addr[w], rf_data_in=wdata[w], rf_wr_en=we[w].
  - Otherwise: gnt=0, rf_wr_en=0, state IDLE. rf_rd_sel, rf_wr_sel and rf_data_in hold their values.
- Back-to-back ISSUE cycles are allowed: one transaction per cycle at full throughput whenever two or more requesters alternate.
- Timing for a request seen at edge E:
  - gnt and RF controls are high during cycle E..E+1.
  - A write commits in the RF at edge E+1.
  - A read samples rf_data_out at edge E+1 into rdata, with rvalid[w]=1 during E+1..E+2 (read latency 2 edges from sampling).
  - A write produces no rvalid.
- Requester rules:
  - Hold req, we, addr and wdata stable until gnt is seen.
  - Drop req, or present a new transaction, in the cycle after gnt.
  - A requester keeping req high gets a new grant no sooner than 2 cycles after its previous one, and only if no other requester is eligible ahead of it in round-robin order.
- Fairness: with all requesters asserting continuously, grants rotate 0,1,2,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 grants.
- Read-after-write to the same address from any requester, in a later grant, returns the new data, because the write commits before the next issue cycle's read.
- Write to address 0 is treated like any other address; the arbiter adds no special register semantics.
- rdata holds its last value when rvalid=0.

Decomposition:
- Shared package rf_pkg: constants RF_AW=4, RF_DW=8, RF_DEPTH=16, and the FSM state type (IDLE, ISSUE).
- One sub-module, rr_pick: combinational round-robin priority picker. Inputs eligible vector and last pointer; outputs one-hot winner and index. Reusable by other arbiters.

Test Plan:
- Reset behaviour: drive reset=0 mid-transaction while req[1]=1 with we=1, addr=5, data=9 -> rf_wr_en drops to 0 immediately, all gnt/rvalid outputs are 0, and RF reg 5 is unchanged.
- Single write then read: req0 writes addr 5, data 9; later req0 reads addr 5 -> gnt[0] pulses twice; rvalid[0] pulses 2 edges after the read is sampled with rdata=9.
- Round-robin rotation: all 4 requesters read with req held until their own gnt -> gnt order 0,1,2,3; each gnt is one cycle; the four issue cycles are back-to-back.
- Masking: only req2 asserted continuously (reading) -> gnt[2] pulses every other cycle, never in two consecutive cycles.
- Cross-requester read-after-write:
  - req1 writes addr 2 data 6 in the same cycle req3 requests a read of addr 2.
  - Response: req1 wins first (pointer after reset), then req3 reads rdata=6.
- Write with no read response: req0 writes addr 1, data 2 -> no rvalid bit ever asserts for this transaction, and a subsequent read of addr 1 returns 2.
